// File: rtl/cv32e40p_aligner_ft_pkg.sv
// Shared types and constants for the fault-tolerant instruction aligner.
package cv32e40p_pkg2_ft;

  // Aligner state: buffer empty, one buffered halfword, or skipping the
  // low half of the first word after a branch to a misaligned target.
  typedef enum logic [1:0] {
    ALIGNED    = 2'b00,
    MISALIGNED = 2'b01,
    BRANCH_MIS = 2'b10
  } align_state_e;

  // The one encoding that can only be reached through a fault.
  localparam logic [1:0] ALIGN_ILLEGAL = 2'b11;

  // A halfword starts a full 32-bit instruction when its two LSBs are set.
  function automatic logic is_full_instr(input logic [1:0] low_bits);
    return low_bits == 2'b11;
  endfunction

endpackage

// File: rtl/cv32e40p_aligner_ft_tmr_reg.sv
// Triplicated async-reset register with per-copy write corruption,
// bitwise majority vote and a copy-disagreement flag.
module cv32e40p_tmr_reg #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              TMR       = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   d,
  input  logic [3*WIDTH-1:0] flip,
  output logic [WIDTH-1:0]   q,
  output logic               mismatch
);

  if (TMR) begin : g_tmr
    logic [WIDTH-1:0] copy0, copy1, copy2;

    // Every copy is rewritten each cycle with the voted next value, so a
    // single upset is scrubbed on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        copy0 <= RESET_VAL;
        copy1 <= RESET_VAL;
        copy2 <= RESET_VAL;
      end else begin
        copy0 <= d ^ flip[0*WIDTH +: WIDTH];
        copy1 <= d ^ flip[1*WIDTH +: WIDTH];
        copy2 <= d ^ flip[2*WIDTH +: WIDTH];
      end
    end

    assign q        = (copy0 & copy1) | (copy0 & copy2) | (copy1 & copy2);
    assign mismatch = |((copy0 ^ q) | (copy1 ^ q) | (copy2 ^ q));
  end else begin : g_single
    logic [WIDTH-1:0] copy0;
    logic             unused_flip;

    // Single unprotected copy; only copy 0's corruption path exists.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) copy0 <= RESET_VAL;
      else        copy0 <= d ^ flip[0*WIDTH +: WIDTH];
    end

    assign q           = copy0;
    assign mismatch    = 1'b0;
    assign unused_flip = ^flip[3*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/cv32e40p_aligner_ft.sv
// Instruction aligner feeding the fault-tolerant compressed decoder.
// Turns word-aligned fetch words into one 16/32-bit instruction per
// handshake; state, pc and halfword buffer live in voted TMR registers.
module cv32e40p_aligner_ft
  import cv32e40p_pkg2_ft::*;
#(
  parameter int unsigned TMR_REGS = 1,
  parameter logic [31:0] BOOT_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_consume_o,
  input  logic        if_valid_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_aligned_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic [2:0]  inject_i,
  output logic        err_corrected_o,
  output logic        err_detected_o
);

  localparam bit USE_TMR = (TMR_REGS != 0);

  logic [1:0]   state_q;
  align_state_e state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  h_q, h_d;
  logic         state_err, pc_err, h_err;
  logic [95:0]  pc_flip;
  logic         unused_addr;

  assign pc_flip = {{30'b0, inject_i[2], 1'b0},
                    {30'b0, inject_i[1], 1'b0},
                    {30'b0, inject_i[0], 1'b0}};
  assign unused_addr = branch_addr_i[0];

  cv32e40p_tmr_reg #(.WIDTH(2), .RESET_VAL(ALIGNED), .TMR(USE_TMR)) u_state_reg (
    .clk(clk), .rst_n(rst_n), .d(state_d), .flip('0), .q(state_q), .mismatch(state_err)
  );

  cv32e40p_tmr_reg #(.WIDTH(32), .RESET_VAL(BOOT_PC), .TMR(USE_TMR)) u_pc_reg (
    .clk(clk), .rst_n(rst_n), .d(pc_d), .flip(pc_flip), .q(pc_q), .mismatch(pc_err)
  );

  cv32e40p_tmr_reg #(.WIDTH(16), .RESET_VAL(16'h0), .TMR(USE_TMR)) u_h_reg (
    .clk(clk), .rst_n(rst_n), .d(h_d), .flip('0), .q(h_q), .mismatch(h_err)
  );

  assign pc_o            = pc_q;
  assign err_corrected_o = state_err | pc_err | h_err;
  assign err_detected_o  = (state_q == ALIGN_ILLEGAL);

  // Next-state and output logic; branch wins, the illegal encoding is
  // treated as ALIGNED and steered back to a legal state.
  always_comb begin
    state_d         = align_state_e'(state_q);
    pc_d            = pc_q;
    h_d             = h_q;
    instr_valid_o   = 1'b0;
    instr_aligned_o = fetch_rdata_i;
    fetch_consume_o = 1'b0;

    if (branch_i) begin
      pc_d    = {branch_addr_i[31:1], 1'b0};
      h_d     = 16'h0;
      state_d = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
    end else begin
      case (state_q)
        MISALIGNED: begin
          if (!is_full_instr(h_q[1:0])) begin
            instr_aligned_o = {16'h0, h_q};
            instr_valid_o   = 1'b1;
            if (if_valid_i) begin
              pc_d    = pc_q + 32'd2;
              state_d = ALIGNED;
            end
          end else begin
            instr_aligned_o = {fetch_rdata_i[15:0], h_q};
            instr_valid_o   = fetch_valid_i;
            if (fetch_valid_i && if_valid_i) begin
              h_d             = fetch_rdata_i[31:16];
              pc_d            = pc_q + 32'd4;
              fetch_consume_o = 1'b1;
              state_d         = MISALIGNED;
            end
          end
        end
        BRANCH_MIS: begin
          if (fetch_valid_i) begin
            h_d             = fetch_rdata_i[31:16];
            fetch_consume_o = 1'b1;
            state_d         = MISALIGNED;
          end
        end
        default: begin
          state_d       = ALIGNED;
          instr_valid_o = fetch_valid_i;
          if (is_full_instr(fetch_rdata_i[1:0])) begin
            instr_aligned_o = fetch_rdata_i;
            if (fetch_valid_i && if_valid_i) begin
              pc_d            = pc_q + 32'd4;
              fetch_consume_o = 1'b1;
            end
          end else begin
            instr_aligned_o = {16'h0, fetch_rdata_i[15:0]};
            if (fetch_valid_i && if_valid_i) begin
              h_d             = fetch_rdata_i[31:16];
              pc_d            = pc_q + 32'd2;
              fetch_consume_o = 1'b1;
              state_d         = MISALIGNED;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_aligner_ft.sv
// Self-checking bench for cv32e40p_aligner_ft: directed steps followed by a
// random run against a memory-based model of the instruction stream.
module tb_cv32e40p_aligner_ft;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_rdata_i = '0;
  logic        fetch_consume_o;
  logic        if_valid_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_aligned_o;
  logic [31:0] pc_o;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic [2:0]  inject_i = '0;
  logic        err_corrected_o;
  logic        err_detected_o;

  int checks = 0;
  int errors = 0;

  // Program memory seen through the fetch port, filled lazily
  logic [15:0] mem [logic [31:0]];
  logic [31:0] m_pc, m_fa;

  cv32e40p_aligner_ft #(.TMR_REGS(1), .BOOT_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_consume_o(fetch_consume_o), .if_valid_i(if_valid_i),
    .instr_valid_o(instr_valid_o), .instr_aligned_o(instr_aligned_o),
    .pc_o(pc_o), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .inject_i(inject_i), .err_corrected_o(err_corrected_o),
    .err_detected_o(err_detected_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] half_at(input logic [31:0] addr);
    logic [15:0] v;
    if (!mem.exists(addr)) begin
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v[1:0] = 2'b11;
      mem[addr] = v;
    end
    return mem[addr];
  endfunction

  // Drive one cycle of inputs after the falling edge; outputs settle before
  // the next rising edge and are checked in between.
  task automatic applyStimulus(input logic fv, input logic [31:0] rdata,
                               input logic ifv, input logic br,
                               input logic [31:0] baddr, input logic [2:0] inj);
    @(negedge clk);
    fetch_valid_i = fv;
    fetch_rdata_i = rdata;
    if_valid_i    = ifv;
    branch_i      = br;
    branch_addr_i = baddr;
    inject_i      = inj;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic        fv, ifv, br, skip, exp_valid, exp_consume;
    logic [31:0] baddr, rdata, gap, avail, len, exp_instr;
    logic [15:0] lo;

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("rst_valid", instr_valid_o, 1'b0);
    checkOutput("rst_consume", fetch_consume_o, 1'b0);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_errc", err_corrected_o, 1'b0);
    checkOutput("rst_errd", err_detected_o, 1'b0);
    rst_n = 1'b1;

    // Two compressed fetches of the same word
    applyStimulus(1'b1, 32'h0000_4501, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("c1_instr", instr_aligned_o, 32'h0000_4501);
    checkOutput("c1_pc", pc_o, 32'h0);
    checkOutput("c1_valid", instr_valid_o, 1'b1);
    checkOutput("c1_consume", fetch_consume_o, 1'b1);
    applyStimulus(1'b1, 32'h0000_4501, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("c2_instr", instr_aligned_o, 32'h0000_0000);
    checkOutput("c2_pc", pc_o, 32'h2);
    checkOutput("c2_valid", instr_valid_o, 1'b1);
    checkOutput("c2_consume", fetch_consume_o, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("c3_pc", pc_o, 32'h4);
    checkOutput("c3_valid", instr_valid_o, 1'b0);

    // Full 32-bit instruction at pc 0
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, 3'b000);
    checkOutput("br0_valid", instr_valid_o, 1'b0);
    checkOutput("br0_consume", fetch_consume_o, 1'b0);
    applyStimulus(1'b1, 32'h0011_0113, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("rv_instr", instr_aligned_o, 32'h0011_0113);
    checkOutput("rv_pc", pc_o, 32'h0);
    checkOutput("rv_consume", fetch_consume_o, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("rv_pc_next", pc_o, 32'h4);

    // Straddling instruction across two fetch words
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 3'b000);
    applyStimulus(1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("st1_instr", instr_aligned_o, 32'h0000_4501);
    checkOutput("st1_pc", pc_o, 32'h0);
    applyStimulus(1'b1, 32'h1234_0010, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("st2_instr", instr_aligned_o, 32'h0010_0093);
    checkOutput("st2_pc", pc_o, 32'h2);
    checkOutput("st2_consume", fetch_consume_o, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("st3_instr", instr_aligned_o, 32'h0000_1234);
    checkOutput("st3_pc", pc_o, 32'h6);
    checkOutput("st3_valid", instr_valid_o, 1'b1);
    checkOutput("st3_consume", fetch_consume_o, 1'b0);

    // Branch to a misaligned target
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0103, 3'b000);
    checkOutput("bm_valid", instr_valid_o, 1'b0);
    checkOutput("bm_consume", fetch_consume_o, 1'b0);
    applyStimulus(1'b1, 32'h4505_ABCD, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("bm_skip_valid", instr_valid_o, 1'b0);
    checkOutput("bm_skip_consume", fetch_consume_o, 1'b1);
    checkOutput("bm_skip_pc", pc_o, 32'h102);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'b000);
    checkOutput("bm_instr", instr_aligned_o, 32'h0000_4505);
    checkOutput("bm_pc", pc_o, 32'h102);
    checkOutput("bm_valid2", instr_valid_o, 1'b1);

    // Downstream stall holds everything
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h0011_0113, 1'b0, 1'b0, 32'h0, 3'b000);
      checkOutput("stall_valid", instr_valid_o, 1'b1);
      checkOutput("stall_instr", instr_aligned_o, 32'h0011_0113);
      checkOutput("stall_consume", fetch_consume_o, 1'b0);
      checkOutput("stall_pc", pc_o, 32'h104);
    end

    // Single-copy fault is masked then scrubbed
    applyStimulus(1'b1, 32'h0011_0113, 1'b1, 1'b0, 32'h0, 3'b001);
    checkOutput("inj1_pc", pc_o, 32'h104);
    checkOutput("inj1_errc_now", err_corrected_o, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("inj1_pc_next", pc_o, 32'h108);
    checkOutput("inj1_errc", err_corrected_o, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("inj1_scrub_pc", pc_o, 32'h108);
    checkOutput("inj1_scrub_errc", err_corrected_o, 1'b0);
    checkOutput("inj1_errd", err_detected_o, 1'b0);

    // Two corrupted copies outvote the good one
    applyStimulus(1'b1, 32'h0011_0113, 1'b1, 1'b0, 32'h0, 3'b011);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("inj2_pc", pc_o, 32'h10E);
    checkOutput("inj2_errc", err_corrected_o, 1'b1);

    // Random run against the stream model
    @(negedge clk);
    fetch_valid_i = 1'b0;
    if_valid_i    = 1'b0;
    branch_i      = 1'b0;
    inject_i      = 3'b000;
    rst_n         = 1'b0;
    #2;
    rst_n = 1'b1;
    m_pc  = 32'h0;
    m_fa  = 32'h0;
    for (int n = 0; n < 600; n++) begin
      fv  = ($urandom_range(0, 3) != 0);
      ifv = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) baddr = 32'($urandom_range(0, 64));
      else                           baddr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      rdata = {half_at(m_fa + 32'd2), half_at(m_fa)};

      // Halfwords from pc up to fa are buffered; fa..fa+3 is on the port.
      gap       = m_fa - m_pc;
      skip      = (gap == 32'hFFFF_FFFE);
      lo        = half_at(m_pc);
      len       = (lo[1:0] == 2'b11) ? 32'd4 : 32'd2;
      avail     = gap + (fv ? 32'd4 : 32'd0);
      exp_valid = !br && !skip && (len <= avail);
      exp_instr = (len == 32'd4) ? {half_at(m_pc + 32'd2), lo} : {16'h0, lo};
      if (skip) exp_consume = fv && !br;
      else      exp_consume = fv && exp_valid && ifv && (len > gap);

      applyStimulus(fv, rdata, ifv, br, baddr, 3'b000);
      checkOutput("rnd_valid", instr_valid_o, exp_valid);
      checkOutput("rnd_consume", fetch_consume_o, exp_consume);
      checkOutput("rnd_pc", pc_o, m_pc);
      if (exp_valid) checkOutput("rnd_instr", instr_aligned_o, exp_instr);
      checkOutput("rnd_err", {err_corrected_o, err_detected_o}, 2'b00);

      if (br) begin
        m_pc = {baddr[31:1], 1'b0};
        m_fa = {baddr[31:2], 2'b00};
      end else if (skip) begin
        if (fv) m_fa = m_fa + 32'd4;
      end else if (exp_valid && ifv) begin
        m_pc = m_pc + len;
        if (exp_consume) m_fa = m_fa + 32'd4;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
